// File: rtl/sdio_cmd_slave_if.sv
// Application-side handshake of the SDIO CMD engine: command requests out, responses in.
interface sdio_cmd_slave_if;
   logic        req_valid;
   logic [5:0]  req_cmd;
   logic [31:0] req_arg;
   logic        resp_valid;
   logic [31:0] resp_arg;

   modport slave  (input resp_valid, resp_arg, output req_valid, req_cmd, req_arg);
   modport master (input req_valid, req_cmd, req_arg, output resp_valid, resp_arg);
endinterface

// File: rtl/sdio_cmd_slave.sv
// SD/SDIO card-side CMD line engine: receives 48-bit command tokens, checks them,
// hands valid ones to the application and returns its response with a fresh CRC7.
module sdio_cmd_slave #(
   parameter int NCR_MIN = 2
) (
   input  logic             clk,
   input  logic             rst,
   inout  wire              cmd_sdio,
   sdio_cmd_slave_if.slave  bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RX   = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] TX   = 2'd3;
   localparam logic [7:0] NCR  = 8'(NCR_MIN);

   logic [1:0]  state;
   logic [46:0] sr;
   logic [6:0]  crc;
   logic [5:0]  bit_cnt;
   logic [7:0]  wait_cnt;
   logic        resp_got;
   logic [31:0] resp_q;
   logic        cmd_out;
   logic        cmd_oe;
   logic        cmd_in;
   logic        tok_ok;
   logic        start_tx;

   // The external pull-up turns a released line into a 1.
   assign cmd_sdio = cmd_oe ? cmd_out : 1'bz;
   assign cmd_in   = cmd_sdio;

   function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = c[6] ^ b;
      return {c[5:3], c[2] ^ fb, c[1:0], fb};
   endfunction

   // Evaluated while the end bit is on the line: bits 0..46 already sit in sr.
   assign tok_ok   = sr[45] && (sr[6:0] == crc) && cmd_in;
   assign start_tx = (bus.resp_valid || resp_got) && (wait_cnt >= NCR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sr            <= '0;
         crc           <= '0;
         bit_cnt       <= '0;
         wait_cnt      <= '0;
         resp_got      <= 1'b0;
         resp_q        <= '0;
         cmd_out       <= 1'b1;
         cmd_oe        <= 1'b0;
         bus.req_valid <= 1'b0;
         bus.req_cmd   <= '0;
         bus.req_arg   <= '0;
      end else begin
         bus.req_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (!cmd_in) begin
                  state   <= RX;
                  sr      <= '0;
                  crc     <= '0;
                  bit_cnt <= 6'd1;
               end
            end
            RX: begin
               sr      <= {sr[45:0], cmd_in};
               bit_cnt <= bit_cnt + 6'd1;
               if (bit_cnt < 6'd40) crc <= crc_step(crc, cmd_in);
               if (bit_cnt == 6'd47) begin
                  if (tok_ok) begin
                     bus.req_valid <= 1'b1;
                     bus.req_cmd   <= sr[44:39];
                     bus.req_arg   <= sr[38:7];
                     wait_cnt      <= 8'd1;
                     resp_got      <= 1'b0;
                     state         <= WAIT;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt < NCR) wait_cnt <= wait_cnt + 8'd1;
               if (bus.resp_valid) begin
                  resp_q   <= bus.resp_arg;
                  resp_got <= 1'b1;
               end
               // Start bit goes out here; the rest of the first 40 bits queue up in sr.
               if (start_tx) begin
                  state    <= TX;
                  cmd_oe   <= 1'b1;
                  cmd_out  <= 1'b0;
                  sr[38:0] <= {1'b0, bus.req_cmd, bus.resp_valid ? bus.resp_arg : resp_q};
                  crc      <= '0;
                  bit_cnt  <= 6'd1;
               end
            end
            default: begin
               bit_cnt <= bit_cnt + 6'd1;
               if (bit_cnt < 6'd40) begin
                  cmd_out  <= sr[38];
                  sr[38:0] <= {sr[37:0], 1'b0};
                  crc      <= crc_step(crc, sr[38]);
               end else if (bit_cnt < 6'd47) begin
                  cmd_out <= crc[6];
                  crc     <= {crc[5:0], 1'b0};
               end else if (bit_cnt == 6'd47) begin
                  cmd_out <= 1'b1;
               end else begin
                  cmd_oe  <= 1'b0;
                  cmd_out <= 1'b1;
                  state   <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sdio_cmd_slave.sv
// Randomised bench for sdio_cmd_slave: a host drives tokens, an application answers,
// and responses/timing are compared against frames built from the CRC7 polynomial.
`timescale 1ns/1ps
module tb_sdio_cmd_slave;
   localparam int NCR_MIN = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic host_oe = 1'b0;
   logic host_bit = 1'b1;
   wire  cmd_line;

   assign cmd_line = host_oe ? host_bit : 1'bz;
   pullup (cmd_line);

   sdio_cmd_slave_if bus ();

   sdio_cmd_slave #(.NCR_MIN(NCR_MIN)) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_sdio (cmd_line),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // CRC7 as the remainder of d(x)*x^7 divided by x^7+x^3+1.
   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [46:0] v;
      v = {d, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
      return v[6:0];
   endfunction

   function automatic logic [47:0] frame(input logic [1:0] hdr, input logic [5:0] idx,
                                         input logic [31:0] a);
      logic [39:0] d;
      d = {hdr, idx, a};
      return {d, crc7(d), 1'b1};
   endfunction

   // Response monitor: collects every frame the card puts on the line.
   logic        cap = 1'b0;
   int          ncap = 0;
   int          rstart = 0;
   logic [47:0] rbits = '0;
   logic [47:0] resp_q[$];
   int          rcyc_q[$];

   always @(negedge clk) begin
      if (!host_oe && !rst) begin
         if (!cap) begin
            if (cmd_line == 1'b0) begin
               cap = 1'b1; ncap = 1; rbits = '0; rstart = cyc;
            end
         end else begin
            rbits = {rbits[46:0], cmd_line};
            ncap++;
            if (ncap == 48) begin
               resp_q.push_back(rbits);
               rcyc_q.push_back(rstart);
               cap = 1'b0;
            end
         end
      end
   end

   logic [5:0]  m_cmd = '0;
   logic [31:0] m_arg = '0;

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic reset_dut;
      tick;
      rst = 1'b1; host_oe = 1'b0;
      tick;
      tick;
      chk("rst_req_valid", bus.req_valid, 0);
      chk("rst_req_cmd", bus.req_cmd, 0);
      chk("rst_req_arg", bus.req_arg, 0);
      chk("rst_line", cmd_line, 1);
      rst = 1'b0;
      cap = 1'b0;
      resp_q.delete();
      rcyc_q.delete();
      m_cmd = '0; m_arg = '0;
   endtask

   task automatic send(input logic [47:0] tok, input int idle, output int e);
      for (int i = 0; i < idle; i++) begin tick; host_oe = 1'b1; host_bit = 1'b1; end
      for (int i = 47; i >= 0; i--) begin tick; host_oe = 1'b1; host_bit = tok[i]; end
      tick;
      host_oe = 1'b0; host_bit = 1'b1;
      e = cyc;
   endtask

   task automatic txn(input logic [47:0] tok, input bit acc, input bit answer,
                      input logic [31:0] rarg, input logic [47:0] exp_resp,
                      input int dly, input int idle);
      int e, r, t, k, st;
      logic spur;
      logic [47:0] got;
      send(tok, idle, e);
      chk("req_valid", bus.req_valid, acc);
      if (acc) begin
         m_cmd = tok[45:40];
         m_arg = tok[39:8];
      end
      chk("req_cmd", bus.req_cmd, m_cmd);
      chk("req_arg", bus.req_arg, m_arg);
      tick;
      chk("req_pulse", bus.req_valid, 0);
      if (acc && answer) begin
         repeat (dly) tick;
         bus.resp_valid = 1'b1; bus.resp_arg = rarg;
         r = cyc + 1;
         tick;
         bus.resp_valid = 1'b0; bus.resp_arg = $urandom;
         t = (r > e + NCR_MIN) ? r : e + NCR_MIN;
         k = 0;
         while (resp_q.size() == 0 && k < 128) begin tick; k++; end
         if (resp_q.size() == 0) begin
            chk("resp_timeout", 0, 1);
         end else begin
            got = resp_q.pop_front();
            st  = rcyc_q.pop_front();
            chk("resp_bits", got, exp_resp);
            chk("resp_start", st, t);
         end
      end else begin
         spur = 1'b0;
         repeat (60) begin tick; spur |= bus.req_valid; end
         chk("line_z", resp_q.size() + int'(cap), 0);
         chk("no_req", spur, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [47:0] tok;
      logic [5:0]  idx;
      logic [31:0] arg, rarg;
      logic [6:0]  m;
      int          ct, k, e;
      logic        bad;
      bus.resp_valid = 1'b0;
      bus.resp_arg   = '0;
      reset_dut;

      // CMD63 from the literal byte stream, answered immediately (tightest NCR case).
      txn(48'h7FF0000F0F0B, 1, 1, 32'hF00FF00F, 48'h3FF00FF00FFB, 0, 16);
      // Same token with a broken CRC: rejected, previous request fields held.
      txn(48'h7FF0000F0F0D, 0, 0, '0, '0, 0, 4);
      // Back-to-back valid tokens separated by a single idle 1.
      txn(frame(2'b01, 6'h05, 32'h1234_5678), 1, 1, 32'hCAFE_0001, frame(2'b00, 6'h05, 32'hCAFE_0001), 1, 1);
      txn(frame(2'b01, 6'h2A, 32'h0000_0001), 1, 1, 32'h8000_0000, frame(2'b00, 6'h2A, 32'h8000_0000), 3, 1);

      for (int n = 0; n < 10; n++) begin
         idx  = 6'($urandom);
         arg  = $urandom;
         rarg = $urandom;
         ct   = $urandom_range(0, 5);
         tok  = frame(2'b01, idx, arg);
         if (ct == 3) begin m = 7'd1 << $urandom_range(0, 6); tok[7:1] = tok[7:1] ^ m; end
         if (ct == 4) tok = frame(2'b00, idx, arg);
         if (ct == 5) tok[0] = 1'b0;
         txn(tok, ct < 3, 1, rarg, frame(2'b00, idx, rarg), $urandom_range(0, 4), $urandom_range(1, 4));
      end

      // Accepted command that never gets a response: line stays released, then reset.
      txn(frame(2'b01, 6'h11, 32'hDEAD_BEEF), 1, 0, '0, '0, 0, 3);
      reset_dut;

      // Reset while bit 20 of a response is on the line; remaining payload bits are 0.
      send(frame(2'b01, 6'h07, 32'h0F0F_0F0F), 2, e);
      tick;
      bus.resp_valid = 1'b1; bus.resp_arg = 32'h0;
      tick;
      bus.resp_valid = 1'b0;
      k = 0;
      while (!(cap && ncap == 21) && k < 200) begin tick; k++; end
      chk("tx_bit20_reached", k < 200, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      cap = 1'b0;
      bad = 1'b0;
      repeat (8) begin bad |= (cmd_line != 1'b1); tick; end
      chk("rst_mid_tx_release", bad, 0);
      chk("rst_mid_tx_no_frame", resp_q.size(), 0);
      chk("rst_mid_tx_req_cmd", bus.req_cmd, 0);
      m_cmd = '0; m_arg = '0;
      txn(frame(2'b01, 6'h3F, 32'hF000_0F0F), 1, 1, 32'hF00FF00F, 48'h3FF00FF00FFB, 2, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
